// File: rtl/load_store_unit.sv
// Load/store unit between the EX/MEM pipeline stage and a word-wide data memory.
// Requests are accepted only in IDLE. The request fields are latched on the
// accept edge. Sub-word stores do a read-modify-write of the full word.
// Loads are aligned and then sign- or zero-extended before being returned.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Address,
    input  logic [31:0] StoreData,
    output logic        RespValid,
    output logic [31:0] LoadData,
    output logic        Fault,
    output logic [31:0] MemAddr,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_WRITE  = 2'b10,
        ST_RESP   = 2'b11
    } state_e;

    localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;      // store source, later the merged word
    logic [31:0] load_data_q, load_data_d;
    logic        fault_q, fault_d;
    logic        fault_s;

    // Select the addressed lane of a read word and extend it to 32 bits.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] result;
        lane_b = word[{off, 3'b000} +: 8];
        lane_h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  result = {{24{lane_b[7]}}, lane_b};
            3'b001:  result = {{16{lane_h[15]}}, lane_h};
            3'b100:  result = {24'd0, lane_b};
            3'b101:  result = {16'd0, lane_h};
            default: result = word;
        endcase
        return result;
    endfunction

    // Insert the store lane into the captured memory word.
    function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                                input logic [31:0] sdata,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [31:0] result;
        result = old_word;
        case (f3[1:0])
            2'b00: result[{off, 3'b000} +: 8] = sdata[7:0];
            2'b01: begin
                if (off[1]) begin
                    result[31:16] = sdata[15:0];
                end else begin
                    result[15:0] = sdata[15:0];
                end
            end
            default: result = sdata;
        endcase
        return result;
    endfunction

    // Accept-time legality: encoding, store width, alignment, range.
    always_comb begin
        fault_s = 1'b0;
        case (Funct3)
            3'b000, 3'b100: fault_s = 1'b0;
            3'b001, 3'b101: fault_s = Address[0];
            3'b010:         fault_s = (Address[1:0] != 2'b00);
            default:        fault_s = 1'b1;
        endcase
        if (ReqWrite && Funct3[2]) begin
            fault_s = 1'b1;
        end else if ({2'b00, Address[31:2]} >= MEM_WORDS_L) begin
            fault_s = 1'b1;
        end else begin
            fault_s = fault_s;
        end
    end

    // Next-state and datapath updates for the request sequencer.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        fault_d     = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (ReqValid) begin
                    write_d  = ReqWrite;
                    funct3_d = Funct3;
                    addr_d   = Address;
                    wdata_d  = StoreData;
                    if (fault_s) begin
                        fault_d = 1'b1;
                        state_d = ST_RESP;
                    end else if (ReqWrite && (Funct3 == 3'b010)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (write_q) begin
                    wdata_d = merge_store(MemRData, wdata_q, funct3_q, addr_q[1:0]);
                    state_d = ST_WRITE;
                end else begin
                    load_data_d = extract_load(MemRData, funct3_q, addr_q[1:0]);
                    fault_d     = 1'b0;
                    state_d     = ST_RESP;
                end
            end
            ST_WRITE: begin
                fault_d = 1'b0;
                state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and request registers; reset abandons any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            load_data_q <= 32'd0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            fault_q     <= fault_d;
        end
    end

    assign ReqReady  = (state_q == ST_IDLE);
    assign RespValid = (state_q == ST_RESP);
    assign MemRead   = (state_q == ST_ACCESS);
    assign MemWrite  = (state_q == ST_WRITE);
    assign MemWData  = (state_q == ST_WRITE) ? wdata_q : 32'd0;
    assign MemAddr   = (state_q == ST_IDLE) ? 32'd0 : {addr_q[31:2], 2'b00};
    assign LoadData  = load_data_q;
    assign Fault     = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases, then random
// requests compared against a word-array reference model.
module tb_load_store_unit;

    localparam int unsigned MEM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic        ReqWrite = 1'b0;
    logic [2:0]  Funct3 = 3'b000;
    logic [31:0] Address = 32'd0;
    logic [31:0] StoreData = 32'd0;
    logic        RespValid;
    logic [31:0] LoadData;
    logic        Fault;
    logic [31:0] MemAddr;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemWData;
    logic [31:0] MemRData;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem     [0:MEM_WORDS-1];
    logic [31:0] ref_mem [0:MEM_WORDS-1];
    logic [31:0] model_load = 32'd0;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .Funct3(Funct3), .Address(Address), .StoreData(StoreData),
        .RespValid(RespValid), .LoadData(LoadData), .Fault(Fault),
        .MemAddr(MemAddr), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemWData(MemWData), .MemRData(MemRData)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, word write on rising edge.
    assign MemRData = (MemAddr[31:12] == 20'd0) ? mem[MemAddr[11:2]] : 32'd0;
    always @(posedge clk) begin
        if (MemWrite && (MemAddr[31:12] == 20'd0)) mem[MemAddr[11:2]] <= MemWData;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference rules, written arithmetically from the request semantics.
    function automatic bit model_fault(input bit wr, input logic [2:0] f3, input logic [31:0] addr);
        int unsigned sz;
        case (f3)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            default:    return 1'b1;
        endcase
        if (wr && (f3 >= 3'd4)) return 1'b1;
        if ((addr % sz) != 0) return 1'b1;
        if ((addr / 4) >= MEM_WORDS) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_extract(input logic [31:0] word, input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] v;
        logic [31:0] off;
        off = addr % 4;
        case (f3)
            3'd0, 3'd4: begin
                v = (word >> (8 * off)) & 32'hFF;
                if ((f3 == 3'd0) && (v >= 32'd128)) v = v - 32'd256;
            end
            3'd1, 3'd5: begin
                v = (word >> (8 * (off & 32'd2))) & 32'hFFFF;
                if ((f3 == 3'd1) && (v >= 32'd32768)) v = v - 32'd65536;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] word, input logic [31:0] sd, input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] mask;
        logic [31:0] sh;
        case (f3)
            3'd0:    begin sh = 8 * (addr % 4);          mask = 32'hFF << sh;   end
            3'd1:    begin sh = 8 * ((addr % 4) & 32'd2); mask = 32'hFFFF << sh; end
            default: begin sh = 32'd0;                    mask = 32'hFFFFFFFF;   end
        endcase
        return (word & ~mask) | ((sd << sh) & mask);
    endfunction

    // Issue one request from IDLE and check its response against the model.
    task automatic do_req(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sd, input string tag);
        bit          f;
        bit          exp_rd;
        bit          exp_wr;
        bit          saw_rd;
        bit          saw_wr;
        bit          got;
        int          exp_lat;
        int          lat;
        logic [31:0] widx;
        f = model_fault(wr, f3, addr);
        if (f) exp_lat = 1;
        else if (wr && (f3 == 3'd2)) exp_lat = 2;
        else if (wr) exp_lat = 3;
        else exp_lat = 2;
        exp_rd = !f && !(wr && (f3 == 3'd2));
        exp_wr = !f && wr;
        widx = addr / 4;
        if (!f) begin
            if (wr) ref_mem[widx] = model_merge(ref_mem[widx], sd, f3, addr);
            else    model_load    = model_extract(ref_mem[widx], f3, addr);
        end
        ReqValid = 1'b1; ReqWrite = wr; Funct3 = f3; Address = addr; StoreData = sd;
        lat = 0; saw_rd = 1'b0; saw_wr = 1'b0; got = 1'b0;
        while (!got && (lat < 10)) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                ReqValid = 1'b0;
                Address = $urandom; StoreData = $urandom; Funct3 = 3'($urandom_range(0, 7));
            end
            saw_rd = saw_rd | MemRead;
            saw_wr = saw_wr | MemWrite;
            if (RespValid) got = 1'b1;
        end
        check_eq({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, ".fault"}, 32'(Fault), 32'(f));
        check_eq({tag, ".ldata"}, LoadData, model_load);
        check_eq({tag, ".memrd"}, 32'(saw_rd), 32'(exp_rd));
        check_eq({tag, ".memwr"}, 32'(saw_wr), 32'(exp_wr));
        if (!f) check_eq({tag, ".mem"}, mem[widx], ref_mem[widx]);
        @(negedge clk);
        check_eq({tag, ".idle"}, {27'd0, ReqReady, RespValid, MemRead, MemWrite, 1'b0}, 32'b10000);
        check_eq({tag, ".idleaddr"}, MemAddr | MemWData, 32'd0);
    endtask

    initial begin
        int acc;
        int resp;
        int exp_acc;
        int wait_cnt;
        int bad_words;
        logic [31:0] w;
        bit          rwr;
        logic [2:0]  rf3;
        logic [31:0] raddr;
        int          sel;

        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            w = $urandom;
            mem[i] <= w;
            ref_mem[i] = w;
        end
        #12;
        check_eq("rst.ctrl", {26'd0, ReqReady, RespValid, Fault, MemRead, MemWrite, 1'b0}, 32'b100000);
        check_eq("rst.ldata", LoadData, 32'd0);
        check_eq("rst.maddr", MemAddr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "sw");
        do_req(1'b0, 3'd2, 32'h10, 32'd0, "lw");
        check_eq("lw.const", LoadData, 32'hDEADBEEF);

        do_req(1'b1, 3'd2, 32'h10, 32'h11223344, "sw_b");
        do_req(1'b1, 3'd0, 32'h13, 32'h5A5A5AA5, "sb");
        check_eq("sb.const", mem[4], 32'hA5223344);
        do_req(1'b0, 3'd0, 32'h13, 32'd0, "lb");
        check_eq("lb.const", LoadData, 32'hFFFFFFA5);
        do_req(1'b0, 3'd4, 32'h13, 32'd0, "lbu");
        check_eq("lbu.const", LoadData, 32'h000000A5);

        do_req(1'b1, 3'd2, 32'h10, 32'h11223344, "sw_h");
        do_req(1'b1, 3'd1, 32'h12, 32'h77778001, "sh");
        check_eq("sh.const", mem[4], 32'h80013344);
        do_req(1'b0, 3'd1, 32'h12, 32'd0, "lh");
        check_eq("lh.const", LoadData, 32'hFFFF8001);
        do_req(1'b0, 3'd5, 32'h12, 32'd0, "lhu");
        check_eq("lhu.const", LoadData, 32'h00008001);

        do_req(1'b0, 3'd2, 32'h6, 32'd0, "f_lw6");
        do_req(1'b0, 3'd1, 32'h1001, 32'd0, "f_lh1001");
        do_req(1'b0, 3'd2, 32'h1000, 32'd0, "f_lw1000");
        do_req(1'b1, 3'd4, 32'h20, 32'd1, "f_sbu");
        do_req(1'b0, 3'd3, 32'h20, 32'd0, "f_f3");
        do_req(1'b0, 3'd2, 32'hFFC, 32'd0, "lw_top");

        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom_range(0, 9));
            rwr = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            if (sel == 0)      raddr = $urandom;
            else if (sel == 1) raddr = 32'hFFC + $urandom_range(0, 7);
            else               raddr = $urandom_range(0, 63);
            do_req(rwr, rf3, raddr, $urandom, "rnd");
        end

        // Backpressure: ReqValid held high across back-to-back loads.
        model_load = model_extract(ref_mem[4], 3'd2, 32'h10);
        exp_acc = (9 + 2) / 3;
        ReqValid = 1'b1; ReqWrite = 1'b0; Funct3 = 3'd2; Address = 32'h10;
        acc = ReqReady ? 1 : 0;
        resp = 0;
        for (int k = 1; k < 9; k++) begin
            @(negedge clk);
            if (ReqReady) acc++;
            if (RespValid) resp++;
        end
        ReqValid = 1'b0;
        check_eq("bp.accepts", 32'(acc), 32'(exp_acc));
        check_eq("bp.resps", 32'(resp), 32'(exp_acc));
        check_eq("bp.ldata", LoadData, model_load);
        @(negedge clk);

        // Reset while an sb sits in WRITE: no write, no response.
        ReqValid = 1'b1; ReqWrite = 1'b1; Funct3 = 3'd0; Address = 32'h21; StoreData = 32'h000000C3;
        wait_cnt = 0;
        do begin
            @(negedge clk);
            ReqValid = 1'b0;
            wait_cnt++;
        end while (!MemWrite && (wait_cnt < 6));
        check_eq("rw.reached", 32'(MemWrite), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_load = 32'd0;
        check_eq("rw.ctrl", {27'd0, ReqReady, RespValid, MemRead, MemWrite, Fault}, 32'b10000);
        check_eq("rw.maddr", MemAddr, 32'd0);
        check_eq("rw.ldata", LoadData, model_load);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        resp = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (RespValid) resp++;
        end
        check_eq("rw.resps", 32'(resp), 32'd0);
        check_eq("rw.ready", 32'(ReqReady), 32'd1);
        check_eq("rw.mem", mem[8], ref_mem[8]);

        bad_words = 0;
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            if (mem[i] !== ref_mem[i]) bad_words++;
        end
        check_eq("mem.all", 32'(bad_words), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_WORDS, 1024, number of 32-bit words in data memory; word index >= MEM_WORDS is out of range.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 ReqValid  in  1  EX/MEM stage presents a load/store request.
REQ-005 ReqReady  out  1  unit accepts a request this cycle; high exactly when state is IDLE.
REQ-006 ReqWrite  in  1  1 = store, 0 = load.
REQ-007 Funct3  in  3  RV32I width/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 Address  in  32  byte address from the ALU.
REQ-009 StoreData  in  32  store source (rs2).
REQ-010 RespValid  out  1  one-cycle pulse: load data valid, store done, or fault.
REQ-011 LoadData  out  32  aligned, sign/zero-extended load result; held between responses.
REQ-012 Fault  out  1  request rejected; valid with RespValid, held until next response.
REQ-013 MemAddr  out  32  word-aligned address to data memory ({Address[31:2],2'b00}).
REQ-014 MemRead  out  1  memory read strobe.
REQ-015 MemWrite  out  1  memory word write strobe, sampled by memory on rising clk.
REQ-016 MemWData  out  32  full word to write.
REQ-017 MemRData  in  32  memory read data, combinational from MemAddr in the same cycle.

Function
REQ-018 FSM states: IDLE, ACCESS, WRITE, RESP; request fields are latched on the accept edge (ReqValid && ReqReady).
REQ-019 Accept-time checks: fault if Funct3 not in {000,001,010,100,101}, store with Funct3 100/101, h with Address[0]=1, w with Address[1:0]!=0, or Address[31:2] >= MEM_WORDS.
REQ-020 Transitions from IDLE: fault -> RESP; lw-class load or sb/sh -> ACCESS; sw -> WRITE.
REQ-021 ACCESS: MemRead=1, MemAddr driven; MemRData captured on exit. Load -> RESP. sb/sh -> WRITE.
REQ-022 WRITE: MemWrite=1 for exactly one cycle, MemWData = merged word (sb/sh) or StoreData (sw); next RESP.
REQ-023 RESP: RespValid=1 for one cycle, ReqReady=0; next IDLE.
REQ-024 Latency from accept edge N: fault RespValid in N+1; load and sw in N+2; sb/sh in N+3.
REQ-025 Merge: sb replaces byte lane Address[1:0] with StoreData[7:0]; sh replaces halfword lane Address[1] with StoreData[15:0]; other lanes come from the captured read word.
REQ-026 Extract: lb/lh sign-extend the selected lane, lbu/lhu zero-extend it; lw passes the word unchanged.
REQ-027 Faulted requests never assert MemRead or MemWrite; LoadData is unchanged on a fault or store response.
REQ-028 MemRead, MemWrite and MemWData are 0 outside ACCESS/WRITE; MemAddr is 0 in IDLE.
REQ-029 ReqValid while not ReqReady is ignored; there is no request queue.

Reset
REQ-030 rst_n low forces IDLE immediately; RespValid, Fault, MemRead and MemWrite are 0; LoadData and MemAddr are 0; ReqReady is 1.
REQ-031 Reset mid-operation abandons the request: no RespValid, and no memory write occurs if reset asserts before the WRITE clock edge.

Verification
REQ-032 Store then load word: sw 0xDEADBEEF @0x10, then lw @0x10 -> LoadData=0xDEADBEEF, RespValid at N+2 for each request.
REQ-033 Byte store and loads: word @0x10=0x11223344; sb 0xA5 @0x13 -> word 0xA5223344, RespValid N+3. Then lb @0x13 -> 0xFFFFFFA5 and lbu -> 0x000000A5.
REQ-034 Halfword store and load: word 0x11223344; sh 0x8001 @0x12 -> 0x80013344. Then lh @0x12 -> 0xFFFF8001 and lhu -> 0x00008001.
REQ-035 Faults: lw @0x6 -> Fault=1 and RespValid at N+1. lh @0x1001 and lw @0x1000 (MEM_WORDS=1024) -> Fault=1. In all three cases MemRead=MemWrite=0 throughout.
REQ-036 Reset in WRITE: sb in flight, rst_n low before the WRITE edge -> MemWrite=0 at once, memory word unchanged, no RespValid, ReqReady=1 after release.
REQ-037 Backpressure: ReqValid held high across a load -> exactly one accept per IDLE cycle, never an accept during ACCESS, WRITE or RESP.
